commit_unit: RTL and testbench
==============================

Name: commit_unit

Overview:
- Retirement stage; consumes the two-wide commit stream produced by the reorder buffer (slot 0 older than slot 1).
- Maintains the retirement RAT (RRAT) and releases superseded physical registers to the free list.
- Releases stores to the store buffer and sends resolved branch outcomes to the predictor.
- On a committed exception, sequences a pipeline flush: ROB flush pulse, PC redirect, then a timed RRAT-restore window for rename.

Parameters:
ISSUE_WIDTH, 2, commit slots per cycle (fixed at 2 in this revision)
ROB_SIZE, 32, ROB entries; IDX_BITS = $clog2(ROB_SIZE)
PREG_BITS, 6, physical register tag width
ARCH_REGS, 32, architectural registers; index 31 = XZR, never mapped
EXC_VECTOR, 32'h0000_0100, exception handler PC
DRAIN_CYCLES, 2, cycles held in DRAIN after a flush

Ports:
clk  in  1  clock
reset  in  1  reset
commit_valid  in  2  per-slot commit strobe
commit_arch_rd  in  2x5  destination arch reg
commit_phys_rd  in  2xPREG_BITS  new physical tag
commit_exception  in  2  entry faulted
commit_rob_idx  in  2xIDX_BITS  ROB index of entry
commit_is_store  in  2  entry is store
commit_is_branch  in  2  entry is branch
commit_pc  in  2x32  entry PC
commit_branch_taken  in  2  resolved direction
commit_branch_target  in  2x32  resolved target
commit_branch_is_call  in  2  call flag
commit_branch_is_return  in  2  return flag
free_en  out  2  release physical tag
free_preg  out  2xPREG_BITS  tag released
store_commit_en  out  2  store may drain
store_commit_idx  out  2xIDX_BITS  ROB index of store
bp_update_en  out  2  predictor update
bp_update_pc  out  2x32
bp_update_taken  out  2
bp_update_target  out  2x32
bp_update_call  out  2
bp_update_return  out  2
flush_en  out  1  ROB/pipeline flush pulse
flush_ptr  out  IDX_BITS  ROB restart pointer
redirect_en  out  1  fetch redirect pulse
redirect_pc  out  32  redirect target
epc  out  32  PC of faulting instruction
rrat_restore_en  out  1  rename copies RRAT into speculative RAT
rrat_map  out  ARCH_REGS*PREG_BITS  flattened RRAT, entry i at [i*PREG_BITS +: PREG_BITS]
perf_retired  out  32  retired-instruction count
perf_branches  out  32  retired-branch count
perf_exceptions  out  32  exception count

Behaviour:
- Interface: reset reset, asynchronous, active-high; clock clk.
- Reset values:
  - All outputs 0.
  - RRAT entry i = i, so rrat_map shows the identity map.
  - FSM in RUN; drain counter 0.
- Timing: all outputs registered, 1-cycle latency from commit inputs. Pulses last exactly 1 cycle. No backpressure; every committed entry is consumed the cycle it arrives.
- Retire qualification, RUN state only:
  - Slot 0 retires if commit_valid[0] && !commit_exception[0].
  - Slot 1 retires if commit_valid[1] && !commit_exception[1] && commit_valid[0] && !commit_exception[0].
  - Slot 1 with slot 0 invalid is a protocol error; ignore slot 1.
- Retiring slot k with arch_rd != 31:
  - free_en[k] = 1; free_preg[k] = previous RRAT[arch_rd].
  - RRAT[arch_rd] <= phys_rd.
  - arch_rd == 31: no free, no RRAT write.
- Same-cycle alias (both slots retire with the same arch_rd): free_preg[1] = commit_phys_rd[0], not the stale RRAT value. Final RRAT = commit_phys_rd[1].
- Store: store_commit_en[k] = 1 and store_commit_idx[k] = commit_rob_idx[k] for a retiring store.
- Branch: bp_update_* mirrors the slot fields for a retiring branch.
- Exception on the oldest faulting valid slot e (slot 0 has priority):
  - Slot e and all younger slots do not retire.
  - Older slots retire normally in the same cycle.
  - Next cycle: flush_en = 1, flush_ptr = commit_rob_idx[e], redirect_en = 1, redirect_pc = EXC_VECTOR, epc = commit_pc[e] (epc holds until the next exception).
- FSM states RUN -> FLUSH -> DRAIN -> RUN:
  - FLUSH: 1 cycle; issues the pulses above.
  - DRAIN: DRAIN_CYCLES cycles; rrat_restore_en = 1 throughout; all commit inputs ignored.
  - Leave DRAIN when the counter reaches DRAIN_CYCLES-1; accept commits again the following cycle.
- An exception arriving in FLUSH/DRAIN is ignored.
- Async reset in any state returns to RUN immediately and abandons any flush in progress.

Optional Feature:
COMMIT_PERF_CNT_EN:
- Defined: perf_retired adds the number of retiring slots (0-2) per cycle; perf_branches adds retiring branches; perf_exceptions increments on each RUN->FLUSH transition. All wrap modulo 2^32 and reset to 0.
- Undefined: the three counter outputs are tied to 0 and no counter flops are instantiated.

Test Plan:
1. Reset, then slot0 arch 3 / phys 40 valid -> next cycle free_en=01, free_preg[0]=3, RRAT[3]=40.
2. Both slots arch 5, phys 41 then 42 -> free_preg = {41, 5}, RRAT[5]=42.
3. Slot0 arch 31 store rob_idx 7 -> free_en=00, store_commit_en[0]=1, store_commit_idx[0]=7, RRAT unchanged.
4. Slot0 retires arch 2 / phys 50; slot1 exception, pc 0x400, rob_idx 9 -> RRAT[2]=50; next cycle flush_en=1, flush_ptr=9, redirect_pc=0x100, epc=0x400; rrat_restore_en high 2 cycles; a commit presented during DRAIN has no effect.
5. Taken branch in slot0, target 0x80, is_call=1 -> bp_update_en[0]=1, taken=1, target=0x80, call=1; perf_branches +1 when COMMIT_PERF_CNT_EN is defined.
6. Assert reset during DRAIN -> next cycle RUN, rrat_restore_en=0, RRAT identity, perf counters 0.

Source files
------------

// File: rtl/commit_unit_if.sv
// Commit-stage bundle: the two-wide ROB commit stream plus everything retirement drives back out.
// master = ROB side / environment, slave = commit_unit.
interface commit_unit_if #(
   parameter int ROB_SIZE  = 32,
   parameter int PREG_BITS = 6,
   parameter int ARCH_REGS = 32
);
   localparam int IDX_BITS = $clog2(ROB_SIZE);

   logic [1:0]                 commit_valid;
   logic [1:0][4:0]            commit_arch_rd;
   logic [1:0][PREG_BITS-1:0]  commit_phys_rd;
   logic [1:0]                 commit_exception;
   logic [1:0][IDX_BITS-1:0]   commit_rob_idx;
   logic [1:0]                 commit_is_store;
   logic [1:0]                 commit_is_branch;
   logic [1:0][31:0]           commit_pc;
   logic [1:0]                 commit_branch_taken;
   logic [1:0][31:0]           commit_branch_target;
   logic [1:0]                 commit_branch_is_call;
   logic [1:0]                 commit_branch_is_return;

   logic [1:0]                 free_en;
   logic [1:0][PREG_BITS-1:0]  free_preg;
   logic [1:0]                 store_commit_en;
   logic [1:0][IDX_BITS-1:0]   store_commit_idx;
   logic [1:0]                 bp_update_en;
   logic [1:0][31:0]           bp_update_pc;
   logic [1:0]                 bp_update_taken;
   logic [1:0][31:0]           bp_update_target;
   logic [1:0]                 bp_update_call;
   logic [1:0]                 bp_update_return;
   logic                       flush_en;
   logic [IDX_BITS-1:0]        flush_ptr;
   logic                       redirect_en;
   logic [31:0]                redirect_pc;
   logic [31:0]                epc;
   logic                       rrat_restore_en;
   logic [ARCH_REGS*PREG_BITS-1:0] rrat_map;
   logic [31:0]                perf_retired;
   logic [31:0]                perf_branches;
   logic [31:0]                perf_exceptions;

   modport master (
      output commit_valid, commit_arch_rd, commit_phys_rd, commit_exception, commit_rob_idx,
             commit_is_store, commit_is_branch, commit_pc, commit_branch_taken,
             commit_branch_target, commit_branch_is_call, commit_branch_is_return,
      input  free_en, free_preg, store_commit_en, store_commit_idx, bp_update_en, bp_update_pc,
             bp_update_taken, bp_update_target, bp_update_call, bp_update_return, flush_en,
             flush_ptr, redirect_en, redirect_pc, epc, rrat_restore_en, rrat_map,
             perf_retired, perf_branches, perf_exceptions
   );

   modport slave (
      input  commit_valid, commit_arch_rd, commit_phys_rd, commit_exception, commit_rob_idx,
             commit_is_store, commit_is_branch, commit_pc, commit_branch_taken,
             commit_branch_target, commit_branch_is_call, commit_branch_is_return,
      output free_en, free_preg, store_commit_en, store_commit_idx, bp_update_en, bp_update_pc,
             bp_update_taken, bp_update_target, bp_update_call, bp_update_return, flush_en,
             flush_ptr, redirect_en, redirect_pc, epc, rrat_restore_en, rrat_map,
             perf_retired, perf_branches, perf_exceptions
   );
endinterface

// File: rtl/commit_unit.sv
// Retirement stage: RRAT maintenance, preg release, store/branch release and exception flush FSM.
// Optional perf counters are built only when COMMIT_PERF_CNT_EN is defined.
module commit_unit #(
   parameter int          ISSUE_WIDTH  = 2,
   parameter int          ROB_SIZE     = 32,
   parameter int          PREG_BITS    = 6,
   parameter int          ARCH_REGS    = 32,
   parameter logic [31:0] EXC_VECTOR   = 32'h0000_0100,
   parameter int          DRAIN_CYCLES = 2
) (
   input logic          clk,
   input logic          reset,
   commit_unit_if.slave cu
);
   localparam int IDX_BITS = $clog2(ROB_SIZE);
   localparam int XZR      = ARCH_REGS - 1;
   localparam int CNT_BITS = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(DRAIN_CYCLES - 1);

   typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_DRAIN} state_t;

   state_t               state_reg, state_next;
   logic [CNT_BITS-1:0]  drain_cnt_reg, drain_cnt_next;

   logic [PREG_BITS-1:0] rrat_reg  [ARCH_REGS];
   logic [PREG_BITS-1:0] rrat_next [ARCH_REGS];

   logic                   accept;
   logic [ISSUE_WIDTH-1:0] retire;
   logic [ISSUE_WIDTH-1:0] writes;
   logic                   exc_take;
   logic                   exc_slot;
   logic                   restore_next;

   logic [ISSUE_WIDTH-1:0]                free_en_next, free_en_reg;
   logic [ISSUE_WIDTH-1:0][PREG_BITS-1:0] free_preg_next, free_preg_reg;
   logic [ISSUE_WIDTH-1:0]                store_en_next, store_en_reg;
   logic [ISSUE_WIDTH-1:0][IDX_BITS-1:0]  store_idx_next, store_idx_reg;
   logic [ISSUE_WIDTH-1:0]                bp_en_next, bp_en_reg;
   logic [ISSUE_WIDTH-1:0][31:0]          bp_pc_next, bp_pc_reg;
   logic [ISSUE_WIDTH-1:0]                bp_taken_next, bp_taken_reg;
   logic [ISSUE_WIDTH-1:0][31:0]          bp_target_next, bp_target_reg;
   logic [ISSUE_WIDTH-1:0]                bp_call_next, bp_call_reg;
   logic [ISSUE_WIDTH-1:0]                bp_return_next, bp_return_reg;

   logic                 flush_en_reg;
   logic [IDX_BITS-1:0]  flush_ptr_reg;
   logic                 redirect_en_reg;
   logic [31:0]          redirect_pc_reg;
   logic [31:0]          epc_reg;
   logic                 restore_reg;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= ST_RUN;
         drain_cnt_reg <= '0;
      end else begin
         state_reg     <= state_next;
         drain_cnt_reg <= drain_cnt_next;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_next     = state_reg;
      drain_cnt_next = drain_cnt_reg;
      case (state_reg)
         ST_RUN: begin
            if (exc_take) state_next = ST_FLUSH;
         end
         ST_FLUSH: begin
            state_next     = ST_DRAIN;
            drain_cnt_next = '0;
         end
         ST_DRAIN: begin
            if (drain_cnt_reg == CNT_LAST) begin
               state_next     = ST_RUN;
               drain_cnt_next = '0;
            end else begin
               drain_cnt_next = drain_cnt_reg + 1'b1;
            end
         end
         default: begin
            state_next     = ST_RUN;
            drain_cnt_next = '0;
         end
      endcase
   end

   // ---------------- FSM: outputs / retire qualification ----------------
   // A slot retires only if every older slot retired, so a fault or a hole stops the group.
   always_comb begin
      accept       = (state_reg == ST_RUN);
      retire       = '0;
      writes       = '0;
      retire[0]    = accept & cu.commit_valid[0] & ~cu.commit_exception[0];
      retire[1]    = retire[0] & cu.commit_valid[1] & ~cu.commit_exception[1];
      exc_take     = accept & cu.commit_valid[0] &
                     (cu.commit_exception[0] | (cu.commit_valid[1] & cu.commit_exception[1]));
      exc_slot     = ~cu.commit_exception[0];
      restore_next = (state_reg == ST_FLUSH) ||
                     ((state_reg == ST_DRAIN) && (drain_cnt_reg != CNT_LAST));
      for (int k = 0; k < ISSUE_WIDTH; k++)
         writes[k] = retire[k] && (cu.commit_arch_rd[k] != 5'(XZR));
   end

   // ---------------- per-slot release paths ----------------
   genvar gi;
   generate
      for (gi = 0; gi < ISSUE_WIDTH; gi++) begin : g_slot
         logic [PREG_BITS-1:0] prev_map;

         // An older slot renaming the same arch reg this cycle supersedes the stale RRAT entry.
         always_comb begin
            prev_map = rrat_reg[cu.commit_arch_rd[gi]];
            for (int j = 0; j < gi; j++)
               if (writes[j] && (cu.commit_arch_rd[j] == cu.commit_arch_rd[gi]))
                  prev_map = cu.commit_phys_rd[j];
         end

         assign free_en_next[gi]   = writes[gi];
         assign free_preg_next[gi] = writes[gi] ? prev_map : '0;
         assign store_en_next[gi]  = retire[gi] & cu.commit_is_store[gi];
         assign store_idx_next[gi] = store_en_next[gi] ? cu.commit_rob_idx[gi] : '0;
         assign bp_en_next[gi]     = retire[gi] & cu.commit_is_branch[gi];
         assign bp_pc_next[gi]     = bp_en_next[gi] ? cu.commit_pc[gi] : '0;
         assign bp_taken_next[gi]  = bp_en_next[gi] & cu.commit_branch_taken[gi];
         assign bp_target_next[gi] = bp_en_next[gi] ? cu.commit_branch_target[gi] : '0;
         assign bp_call_next[gi]   = bp_en_next[gi] & cu.commit_branch_is_call[gi];
         assign bp_return_next[gi] = bp_en_next[gi] & cu.commit_branch_is_return[gi];
      end

      // Younger slot wins on an alias, so it is applied last.
      for (gi = 0; gi < ARCH_REGS; gi++) begin : g_rrat
         logic [PREG_BITS-1:0] entry_next;
         always_comb begin
            entry_next = rrat_reg[gi];
            for (int j = 0; j < ISSUE_WIDTH; j++)
               if (writes[j] && (cu.commit_arch_rd[j] == 5'(gi)))
                  entry_next = cu.commit_phys_rd[j];
         end
         assign rrat_next[gi] = entry_next;
         assign cu.rrat_map[gi*PREG_BITS +: PREG_BITS] = rrat_reg[gi];
      end
   endgenerate

   // ---------------- registered state and outputs ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < ARCH_REGS; i++)
            rrat_reg[i] <= PREG_BITS'(i);
         free_en_reg     <= '0;
         free_preg_reg   <= '0;
         store_en_reg    <= '0;
         store_idx_reg   <= '0;
         bp_en_reg       <= '0;
         bp_pc_reg       <= '0;
         bp_taken_reg    <= '0;
         bp_target_reg   <= '0;
         bp_call_reg     <= '0;
         bp_return_reg   <= '0;
         flush_en_reg    <= 1'b0;
         flush_ptr_reg   <= '0;
         redirect_en_reg <= 1'b0;
         redirect_pc_reg <= '0;
         epc_reg         <= '0;
         restore_reg     <= 1'b0;
      end else begin
         for (int i = 0; i < ARCH_REGS; i++)
            rrat_reg[i] <= rrat_next[i];
         free_en_reg     <= free_en_next;
         free_preg_reg   <= free_preg_next;
         store_en_reg    <= store_en_next;
         store_idx_reg   <= store_idx_next;
         bp_en_reg       <= bp_en_next;
         bp_pc_reg       <= bp_pc_next;
         bp_taken_reg    <= bp_taken_next;
         bp_target_reg   <= bp_target_next;
         bp_call_reg     <= bp_call_next;
         bp_return_reg   <= bp_return_next;
         flush_en_reg    <= exc_take;
         flush_ptr_reg   <= exc_take ? cu.commit_rob_idx[exc_slot] : '0;
         redirect_en_reg <= exc_take;
         redirect_pc_reg <= exc_take ? EXC_VECTOR : '0;
         if (exc_take)
            epc_reg <= cu.commit_pc[exc_slot];
         restore_reg     <= restore_next;
      end
   end

   assign cu.free_en          = free_en_reg;
   assign cu.free_preg        = free_preg_reg;
   assign cu.store_commit_en  = store_en_reg;
   assign cu.store_commit_idx = store_idx_reg;
   assign cu.bp_update_en     = bp_en_reg;
   assign cu.bp_update_pc     = bp_pc_reg;
   assign cu.bp_update_taken  = bp_taken_reg;
   assign cu.bp_update_target = bp_target_reg;
   assign cu.bp_update_call   = bp_call_reg;
   assign cu.bp_update_return = bp_return_reg;
   assign cu.flush_en         = flush_en_reg;
   assign cu.flush_ptr        = flush_ptr_reg;
   assign cu.redirect_en      = redirect_en_reg;
   assign cu.redirect_pc      = redirect_pc_reg;
   assign cu.epc              = epc_reg;
   assign cu.rrat_restore_en  = restore_reg;

`ifdef COMMIT_PERF_CNT_EN
   logic [31:0] perf_retired_reg, perf_branches_reg, perf_exceptions_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_retired_reg    <= '0;
         perf_branches_reg   <= '0;
         perf_exceptions_reg <= '0;
      end else begin
         perf_retired_reg    <= perf_retired_reg + 32'($countones(retire));
         perf_branches_reg   <= perf_branches_reg + 32'($countones(bp_en_next));
         perf_exceptions_reg <= perf_exceptions_reg + 32'(exc_take);
      end
   end

   assign cu.perf_retired    = perf_retired_reg;
   assign cu.perf_branches   = perf_branches_reg;
   assign cu.perf_exceptions = perf_exceptions_reg;
`else
   assign cu.perf_retired    = '0;
   assign cu.perf_branches   = '0;
   assign cu.perf_exceptions = '0;
`endif

endmodule

// File: tb/tb_commit_unit.sv
// Directed bench for commit_unit: vector table for retire paths, hand sequences for flush and reset.
module tb_commit_unit;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   commit_unit_if #(.ROB_SIZE(32), .PREG_BITS(6), .ARCH_REGS(32)) bus ();

   commit_unit dut (
      .clk   (clk),
      .reset (reset),
      .cu    (bus)
   );

   typedef struct {
      logic [1:0]  valid, exc, store, branch, taken, call, ret;
      logic [4:0]  arch0, arch1, rob0, rob1;
      logic [5:0]  phys0, phys1;
      logic [31:0] pc0, pc1, tgt0, tgt1;
      logic [1:0]  e_free_en, e_store_en, e_bp_en;
      logic [5:0]  e_free0, e_free1;
      logic [4:0]  e_sidx0, e_sidx1;
      logic [4:0]  rrat_idx;
      logic [5:0]  rrat_val;
   } vec_t;

   localparam int NV = 8;
   vec_t vt [NV];
   logic [191:0] id_map;

   task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic logic [5:0] rrat_of(input int i);
      return bus.rrat_map[i*6 +: 6];
   endfunction

   function automatic vec_t blank();
      vec_t v;
      v.valid = 0; v.exc = 0; v.store = 0; v.branch = 0; v.taken = 0; v.call = 0; v.ret = 0;
      v.arch0 = 0; v.arch1 = 0; v.rob0 = 0; v.rob1 = 0; v.phys0 = 0; v.phys1 = 0;
      v.pc0 = 0; v.pc1 = 0; v.tgt0 = 0; v.tgt1 = 0;
      v.e_free_en = 0; v.e_store_en = 0; v.e_bp_en = 0; v.e_free0 = 0; v.e_free1 = 0;
      v.e_sidx0 = 0; v.e_sidx1 = 0; v.rrat_idx = 0; v.rrat_val = 0;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      bus.commit_valid            = v.valid;
      bus.commit_exception        = v.exc;
      bus.commit_arch_rd[0]       = v.arch0;
      bus.commit_arch_rd[1]       = v.arch1;
      bus.commit_phys_rd[0]       = v.phys0;
      bus.commit_phys_rd[1]       = v.phys1;
      bus.commit_rob_idx[0]       = v.rob0;
      bus.commit_rob_idx[1]       = v.rob1;
      bus.commit_is_store         = v.store;
      bus.commit_is_branch        = v.branch;
      bus.commit_pc[0]            = v.pc0;
      bus.commit_pc[1]            = v.pc1;
      bus.commit_branch_taken     = v.taken;
      bus.commit_branch_target[0] = v.tgt0;
      bus.commit_branch_target[1] = v.tgt1;
      bus.commit_branch_is_call   = v.call;
      bus.commit_branch_is_return = v.ret;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic commit_one(input logic [4:0] arch, input logic [5:0] phys);
      vec_t v;
      v = blank();
      v.valid = 2'b01; v.arch0 = arch; v.phys0 = phys;
      drive(v);
   endtask

   task automatic chk_perf(input string tag, input int r, input int b, input int e);
`ifdef COMMIT_PERF_CNT_EN
      chk({tag, ".perf_retired"},    bus.perf_retired,    r);
      chk({tag, ".perf_branches"},   bus.perf_branches,   b);
      chk({tag, ".perf_exceptions"}, bus.perf_exceptions, e);
`else
      chk({tag, ".perf_retired"},    bus.perf_retired,    0);
      chk({tag, ".perf_branches"},   bus.perf_branches,   0);
      chk({tag, ".perf_exceptions"}, bus.perf_exceptions, 0);
`endif
   endtask

   initial begin
      vec_t v;
      for (int i = 0; i < 32; i++) id_map[i*6 +: 6] = 6'(i);

      // v0: single retire, arch 3 -> phys 40
      v = blank(); v.valid = 2'b01; v.arch0 = 3; v.phys0 = 40;
      v.e_free_en = 2'b01; v.e_free0 = 3; v.rrat_idx = 3; v.rrat_val = 40; vt[0] = v;
      // v1: same-cycle alias on arch 5
      v = blank(); v.valid = 2'b11; v.arch0 = 5; v.phys0 = 41; v.arch1 = 5; v.phys1 = 42;
      v.e_free_en = 2'b11; v.e_free0 = 5; v.e_free1 = 41; v.rrat_idx = 5; v.rrat_val = 42; vt[1] = v;
      // v2: store to XZR
      v = blank(); v.valid = 2'b01; v.arch0 = 31; v.phys0 = 60; v.store = 2'b01; v.rob0 = 7;
      v.e_store_en = 2'b01; v.e_sidx0 = 7; v.rrat_idx = 31; v.rrat_val = 31; vt[2] = v;
      // v3: taken call branch in slot 0
      v = blank(); v.valid = 2'b01; v.arch0 = 31; v.branch = 2'b01; v.taken = 2'b01;
      v.call = 2'b01; v.pc0 = 32'h200; v.tgt0 = 32'h80;
      v.e_bp_en = 2'b01; v.rrat_idx = 3; v.rrat_val = 40; vt[3] = v;
      // v4: two writes, slot 1 is also a store
      v = blank(); v.valid = 2'b11; v.arch0 = 6; v.phys0 = 44; v.arch1 = 7; v.phys1 = 45;
      v.store = 2'b10; v.rob1 = 12;
      v.e_free_en = 2'b11; v.e_free0 = 6; v.e_free1 = 7; v.e_store_en = 2'b10; v.e_sidx1 = 12;
      v.rrat_idx = 7; v.rrat_val = 45; vt[4] = v;
      // v5: slot 1 without slot 0 is ignored
      v = blank(); v.valid = 2'b10; v.arch1 = 8; v.phys1 = 46; v.store = 2'b10; v.branch = 2'b10;
      v.rrat_idx = 8; v.rrat_val = 8; vt[5] = v;
      // v6: overwrite arch 3 again, frees phys 40
      v = blank(); v.valid = 2'b01; v.arch0 = 3; v.phys0 = 47;
      v.e_free_en = 2'b01; v.e_free0 = 40; v.rrat_idx = 3; v.rrat_val = 47; vt[6] = v;
      // v7: write in slot 0, not-taken return branch in slot 1
      v = blank(); v.valid = 2'b11; v.arch0 = 9; v.phys0 = 48; v.arch1 = 31;
      v.branch = 2'b10; v.ret = 2'b10; v.pc1 = 32'h300; v.tgt1 = 32'h340;
      v.e_free_en = 2'b01; v.e_free0 = 9; v.e_bp_en = 2'b10; v.rrat_idx = 9; v.rrat_val = 48;
      vt[7] = v;

      drive(blank());
      repeat (3) @(posedge clk);
      #1;
      // reset state while reset is still asserted
      chk("rst.free_en", bus.free_en, 0);
      chk("rst.store_en", bus.store_commit_en, 0);
      chk("rst.bp_en", bus.bp_update_en, 0);
      chk("rst.flush_en", bus.flush_en, 0);
      chk("rst.redirect_en", bus.redirect_en, 0);
      chk("rst.epc", bus.epc, 0);
      chk("rst.restore", bus.rrat_restore_en, 0);
      chk("rst.rrat_map", bus.rrat_map, id_map);
      chk_perf("rst", 0, 0, 0);
      reset = 1'b0;
      $display("reset released");

      for (int i = 0; i < NV; i++) begin
         drive(vt[i]);
         tick();
         drive(blank());
         $display("vec %0d: free_en=%b free_preg=%0d/%0d store_en=%b bp_en=%b", i,
                  bus.free_en, bus.free_preg[0], bus.free_preg[1], bus.store_commit_en, bus.bp_update_en);
         chk($sformatf("v%0d.free_en", i), bus.free_en, vt[i].e_free_en);
         if (vt[i].e_free_en[0]) chk($sformatf("v%0d.free_preg0", i), bus.free_preg[0], vt[i].e_free0);
         if (vt[i].e_free_en[1]) chk($sformatf("v%0d.free_preg1", i), bus.free_preg[1], vt[i].e_free1);
         chk($sformatf("v%0d.store_en", i), bus.store_commit_en, vt[i].e_store_en);
         if (vt[i].e_store_en[0]) chk($sformatf("v%0d.store_idx0", i), bus.store_commit_idx[0], vt[i].e_sidx0);
         if (vt[i].e_store_en[1]) chk($sformatf("v%0d.store_idx1", i), bus.store_commit_idx[1], vt[i].e_sidx1);
         chk($sformatf("v%0d.bp_en", i), bus.bp_update_en, vt[i].e_bp_en);
         chk($sformatf("v%0d.bp_taken", i), bus.bp_update_taken & vt[i].e_bp_en, vt[i].taken & vt[i].e_bp_en);
         chk($sformatf("v%0d.bp_call", i), bus.bp_update_call & vt[i].e_bp_en, vt[i].call & vt[i].e_bp_en);
         chk($sformatf("v%0d.bp_ret", i), bus.bp_update_return & vt[i].e_bp_en, vt[i].ret & vt[i].e_bp_en);
         if (vt[i].e_bp_en[0]) begin
            chk($sformatf("v%0d.bp_pc0", i), bus.bp_update_pc[0], vt[i].pc0);
            chk($sformatf("v%0d.bp_tgt0", i), bus.bp_update_target[0], vt[i].tgt0);
         end
         if (vt[i].e_bp_en[1]) begin
            chk($sformatf("v%0d.bp_pc1", i), bus.bp_update_pc[1], vt[i].pc1);
            chk($sformatf("v%0d.bp_tgt1", i), bus.bp_update_target[1], vt[i].tgt1);
         end
         chk($sformatf("v%0d.rrat", i), rrat_of(vt[i].rrat_idx), vt[i].rrat_val);
         chk($sformatf("v%0d.flush_en", i), bus.flush_en, 0);
      end
      chk_perf("vec", 10, 2, 0);

      // Exception in slot 1, slot 0 retires in the same cycle
      v = blank(); v.valid = 2'b11; v.exc = 2'b10; v.arch0 = 2; v.phys0 = 50;
      v.arch1 = 11; v.phys1 = 51; v.pc1 = 32'h400; v.rob1 = 9;
      drive(v);
      tick();
      $display("exc: flush_en=%b flush_ptr=%0d redirect_pc=%h epc=%h", bus.flush_en,
               bus.flush_ptr, bus.redirect_pc, bus.epc);
      chk("exc.free_en", bus.free_en, 2'b01);
      chk("exc.free_preg0", bus.free_preg[0], 2);
      chk("exc.rrat2", rrat_of(2), 50);
      chk("exc.rrat11", rrat_of(11), 11);
      chk("exc.flush_en", bus.flush_en, 1);
      chk("exc.flush_ptr", bus.flush_ptr, 9);
      chk("exc.redirect_en", bus.redirect_en, 1);
      chk("exc.redirect_pc", bus.redirect_pc, 32'h100);
      chk("exc.epc", bus.epc, 32'h400);
      chk("exc.restore", bus.rrat_restore_en, 0);

      // Commits and a new exception presented through FLUSH and DRAIN must be ignored
      v = blank(); v.valid = 2'b01; v.exc = 2'b01; v.pc0 = 32'h999; v.rob0 = 3;
      drive(v);
      tick();
      chk("flush.flush_en_drop", bus.flush_en, 0);
      chk("flush.redirect_drop", bus.redirect_en, 0);
      chk("drain0.restore", bus.rrat_restore_en, 1);
      commit_one(4, 55);
      tick();
      $display("drain: restore=%b free_en=%b", bus.rrat_restore_en, bus.free_en);
      chk("drain1.restore", bus.rrat_restore_en, 1);
      chk("drain1.free_en", bus.free_en, 0);
      chk("drain1.flush_en", bus.flush_en, 0);
      tick();
      chk("drain_end.restore", bus.rrat_restore_en, 0);
      chk("drain_end.free_en", bus.free_en, 0);
      chk("drain_end.rrat4", rrat_of(4), 4);
      chk("drain_end.epc_hold", bus.epc, 32'h400);
      commit_one(4, 57);
      tick();
      drive(blank());
      $display("resume: free_en=%b free_preg0=%0d", bus.free_en, bus.free_preg[0]);
      chk("resume.free_en", bus.free_en, 2'b01);
      chk("resume.free_preg0", bus.free_preg[0], 4);
      chk("resume.rrat4", rrat_of(4), 57);
      chk_perf("resume", 12, 2, 1);

      // Both slots fault: slot 0 wins; then reset asynchronously during DRAIN
      v = blank(); v.valid = 2'b11; v.exc = 2'b11; v.pc0 = 32'h500; v.rob0 = 3;
      v.pc1 = 32'h600; v.rob1 = 4; v.arch0 = 12; v.phys0 = 20;
      drive(v);
      tick();
      drive(blank());
      chk("exc2.free_en", bus.free_en, 0);
      chk("exc2.flush_ptr", bus.flush_ptr, 3);
      chk("exc2.epc", bus.epc, 32'h500);
      chk("exc2.rrat12", rrat_of(12), 12);
      tick();
      chk("exc2.restore", bus.rrat_restore_en, 1);
      #2;
      reset = 1'b1;
      #1;
      $display("async reset: restore=%b epc=%h", bus.rrat_restore_en, bus.epc);
      chk("arst.restore", bus.rrat_restore_en, 0);
      chk("arst.rrat_map", bus.rrat_map, id_map);
      chk("arst.epc", bus.epc, 0);
      chk_perf("arst", 0, 0, 0);
      #2;
      reset = 1'b0;
      commit_one(10, 33);
      tick();
      drive(blank());
      chk("post_rst.free_en", bus.free_en, 2'b01);
      chk("post_rst.free_preg0", bus.free_preg[0], 10);
      chk("post_rst.rrat10", rrat_of(10), 33);
      chk("post_rst.restore", bus.rrat_restore_en, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
